// File: rtl/zdram_pkg.sv
// Shared owner encodings, DRAM byte-select constants and bus widths for the
// ZX-style DRAM slot arbiter.
package zdram_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

    localparam logic [1:0] BSEL_BOTH = 2'b11;
    localparam logic [1:0] BSEL_HI   = 2'b10;
    localparam logic [1:0] BSEL_LO   = 2'b01;

    // CPU writes touch one byte lane; everything else is a full word.
    function automatic logic [1:0] cpu_bsel(input logic rnw, input logic wrbsel);
        cpu_bsel = rnw ? BSEL_BOTH : (wrbsel ? BSEL_HI : BSEL_LO);
    endfunction

endpackage

// File: rtl/zdram_mux.sv
// DRAM command mux: selects the captured operands of the current slot owner.
// Idle slots present the parked command (addr 0, read, both bytes, data 0).
module zdram_mux
    import zdram_pkg::*;
(
    input  logic [1:0]        owner,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rnw,
    input  logic              cpu_wrbsel,
    input  logic [7:0]        cpu_wrdata,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rnw,
    input  logic [DATA_W-1:0] dma_wrdata,
    output logic [ADDR_W-1:0] addr,
    output logic              rnw,
    output logic [1:0]        bsel,
    output logic [DATA_W-1:0] wrdata
);

    always_comb begin
        addr   = '0;
        rnw    = 1'b1;
        bsel   = BSEL_BOTH;
        wrdata = '0;
        case (owner_t'(owner))
            OWN_VID: addr = vid_addr;
            OWN_CPU: begin
                addr   = cpu_addr;
                rnw    = cpu_rnw;
                bsel   = cpu_bsel(cpu_rnw, cpu_wrbsel);
                wrdata = {cpu_wrdata, cpu_wrdata};
            end
            OWN_DMA: begin
                addr   = dma_addr;
                rnw    = dma_rnw;
                wrdata = dma_wrdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/zdram_arb.sv
// Four-phase DRAM slot arbiter (video > CPU > DMA). The DMA port is only
// arbitrated when ZDRAM_ARB_DMA_EN is defined; otherwise it is inert.
module zdram_arb
    import zdram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              c0,
    input  logic              c1,
    input  logic              c2,
    input  logic              c3,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_strobe,
    output logic [DATA_W-1:0] vid_rddata,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rnw,
    input  logic              cpu_wrbsel,
    input  logic [7:0]        cpu_wrdata,
    output logic              cpu_next,
    output logic              cpu_strobe,
    output logic              cpu_latch,
    output logic [DATA_W-1:0] cpu_rddata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_rnw,
    input  logic [DATA_W-1:0] dma_wrdata,
    output logic              dma_next,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rddata,
    output logic              dram_req,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_rnw,
    output logic [1:0]        dram_bsel,
    output logic [DATA_W-1:0] dram_wrdata,
    input  logic [DATA_W-1:0] dram_rddata
);

    owner_t            owner, owner_nxt, grant;
    logic              dma_grant;
    logic [ADDR_W-1:0] vid_addr_q, cpu_addr_q, dma_addr_q;
    logic              cpu_rnw_q, cpu_wrbsel_q, dma_rnw_q;
    logic [7:0]        cpu_wrdata_q;
    logic [DATA_W-1:0] dma_wrdata_q;
    logic              cpu_rd_slot;
    logic              unused_c1;

    // c1 carries no action of its own; the slot is fully timed by c0/c2/c3.
    assign unused_c1   = c1;
    assign cpu_next    = !vid_req;
    assign dram_req    = c0 && (owner != OWN_IDLE);
    assign cpu_rd_slot = (owner == OWN_CPU) && cpu_rnw_q;

    always_comb begin
        grant = OWN_IDLE;
        if (vid_req)
            grant = OWN_VID;
        else if (cpu_req)
            grant = OWN_CPU;
        else if (dma_grant)
            grant = OWN_DMA;
    end

    // Ownership only changes on c3, so the command is stable for c0..c3.
    always_comb begin
        owner_nxt = owner;
        if (c3)
            owner_nxt = grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            owner <= OWN_IDLE;
        else
            owner <= owner_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_addr_q   <= '0;
            cpu_addr_q   <= '0;
            cpu_rnw_q    <= 1'b1;
            cpu_wrbsel_q <= 1'b0;
            cpu_wrdata_q <= '0;
        end else if (c3) begin
            vid_addr_q   <= vid_addr;
            cpu_addr_q   <= cpu_addr;
            cpu_rnw_q    <= cpu_rnw;
            cpu_wrbsel_q <= cpu_wrbsel;
            cpu_wrdata_q <= cpu_wrdata;
        end
    end

    // Read data lands at the end of c2; strobes are therefore high during c3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_rddata <= '0;
            cpu_rddata <= '0;
            vid_strobe <= 1'b0;
            cpu_strobe <= 1'b0;
            cpu_latch  <= 1'b0;
        end else begin
            vid_strobe <= c2 && (owner == OWN_VID);
            cpu_strobe <= c2 && cpu_rd_slot;
            if (c2 && (owner == OWN_VID))
                vid_rddata <= dram_rddata;
            if (c2 && cpu_rd_slot)
                cpu_rddata <= dram_rddata;
            if (c3 && (grant == OWN_CPU))
                cpu_latch <= 1'b0;
            else if (c2 && cpu_rd_slot)
                cpu_latch <= 1'b1;
        end
    end

`ifdef ZDRAM_ARB_DMA_EN
    assign dma_grant = dma_req;
    assign dma_next  = !vid_req && !cpu_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_addr_q   <= '0;
            dma_rnw_q    <= 1'b1;
            dma_wrdata_q <= '0;
        end else if (c3) begin
            dma_addr_q   <= dma_addr;
            dma_rnw_q    <= dma_rnw;
            dma_wrdata_q <= dma_wrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_ack    <= 1'b0;
            dma_rddata <= '0;
        end else begin
            dma_ack <= c2 && (owner == OWN_DMA);
            if (c2 && (owner == OWN_DMA) && dma_rnw_q)
                dma_rddata <= dram_rddata;
        end
    end
`else
    logic unused_dma;
    assign unused_dma   = ^{dma_req, dma_addr, dma_rnw, dma_wrdata};
    assign dma_grant    = 1'b0;
    assign dma_next     = 1'b0;
    assign dma_ack      = 1'b0;
    assign dma_rddata   = '0;
    assign dma_addr_q   = '0;
    assign dma_rnw_q    = 1'b1;
    assign dma_wrdata_q = '0;
`endif

    zdram_mux u_mux (
        .owner      (owner),
        .vid_addr   (vid_addr_q),
        .cpu_addr   (cpu_addr_q),
        .cpu_rnw    (cpu_rnw_q),
        .cpu_wrbsel (cpu_wrbsel_q),
        .cpu_wrdata (cpu_wrdata_q),
        .dma_addr   (dma_addr_q),
        .dma_rnw    (dma_rnw_q),
        .dma_wrdata (dma_wrdata_q),
        .addr       (dram_addr),
        .rnw        (dram_rnw),
        .bsel       (dram_bsel),
        .wrdata     (dram_wrdata)
    );

endmodule

// File: doc/zdram_arb.md
ZDRAM_ARB -- requirements
Module: zdram_arb

Interface
REQ-001 Parameter: none; the slot period is fixed at 4 clk, phases c0..c3.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 c0, c1, c2, c3  in  1 each  one-hot phase strobes, repeating in the order c0,c1,c2,c3.
REQ-005 vid_req  in  1 / vid_addr  in  21  video fetch request and word address.
REQ-006 vid_strobe  out  1 / vid_rddata  out  16  video data valid pulse and data.
REQ-007 cpu_req  in  1 / cpu_addr  in  21 / cpu_rnw  in  1 / cpu_wrbsel  in  1 / cpu_wrdata  in  8  CPU request, word address, read(1)/write(0), byte select, write byte.
REQ-008 cpu_next  out  1 / cpu_strobe  out  1 / cpu_latch  out  1 / cpu_rddata  out  16  CPU slot-available flag, read-data strobe, hold flag, read word.
REQ-009 dma_req  in  1 / dma_addr  in  21 / dma_rnw  in  1 / dma_wrdata  in  16  DMA request and operands.
REQ-010 dma_next  out  1 / dma_ack  out  1 / dma_rddata  out  16  DMA slot flag, completion pulse, read word.
REQ-011 dram_req  out  1 / dram_addr  out  21 / dram_rnw  out  1 / dram_bsel  out  2 / dram_wrdata  out  16 / dram_rddata  in  16  DRAM command port.

Function
REQ-012 The owner of the next slot SHALL be decided at c3 with priority video > CPU > DMA > idle, and registered as owner[1:0].
REQ-013 cpu_next SHALL equal !vid_req, combinationally.
REQ-014 dma_next SHALL equal !vid_req && !cpu_req, combinationally.
REQ-015 dram_req SHALL be high for exactly the c0 clk of a non-idle slot.
REQ-016 dram_addr, dram_rnw, dram_bsel and dram_wrdata SHALL be held stable from c0 to c3 of that slot.
REQ-017 CPU write: dram_bsel = cpu_wrbsel ? 2'b10 : 2'b01, dram_wrdata = {cpu_wrdata, cpu_wrdata}.
REQ-018 All reads, and DMA writes, SHALL use dram_bsel = 2'b11.
REQ-019 dram_rddata is valid at c2 of a read slot and SHALL be registered at the end of c2 into the owner's read register.
REQ-020 cpu_strobe SHALL pulse during c3 of a CPU read slot, with cpu_rddata already valid.
REQ-021 cpu_latch SHALL rise at c3 of a CPU read slot and fall at the c3 that grants any new CPU slot.
REQ-022 cpu_rddata SHALL hold its value until the next CPU read.
REQ-023 vid_strobe SHALL pulse at c3 of a video slot.
REQ-024 dma_ack SHALL pulse at c3 of every DMA slot, read or write.
REQ-025 DMA operands SHALL be captured at the granting c3, so that a later change of dma_addr does not corrupt the slot in flight.
REQ-026 CPU operands SHALL likewise be captured at the granting c3.
REQ-027 When vid_req, cpu_req and dma_req are all high at c3, video SHALL win and neither cpu_strobe nor dma_ack SHALL pulse in that slot.
REQ-028 A request deasserted before c3 SHALL NOT be granted.
REQ-029 A slot is never aborted once granted.
REQ-030 Idle slots SHALL leave dram_req low and all strobes low.

Reset
REQ-031 On rst, owner SHALL become idle.
REQ-032 On rst, dram_req, cpu_strobe, cpu_latch, vid_strobe and dma_ack SHALL be 0.
REQ-033 On rst, cpu_rddata, vid_rddata, dma_rddata, dram_addr and dram_wrdata SHALL be 0; dram_rnw SHALL be 1; dram_bsel SHALL be 2'b11.
REQ-034 Reset mid-slot SHALL abandon the slot with no strobe.
REQ-035 After rst is released, the first grant SHALL occur at the next c3.

Configuration
REQ-036 Macro ZDRAM_ARB_DMA_EN: when defined, the DMA port SHALL be arbitrated as above.
REQ-037 When ZDRAM_ARB_DMA_EN is undefined, dma_next, dma_ack and dma_rddata SHALL be tied to 0, dma_* inputs SHALL be ignored, and DMA SHALL never own a slot.

Structure
REQ-038 Owner encodings (IDLE=0, VID=1, CPU=2, DMA=3) and the bsel constants SHALL live in a shared package zdram_pkg.
REQ-039 One sub-module, zdram_mux, SHALL hold the combinational DRAM command mux selected by owner.
REQ-040 All registers SHALL stay in zdram_arb.

Verification
REQ-041 CPU read: cpu_req=1, cpu_rnw=1, addr=0x01234 at c3; DRAM returns 0xBEEF at c2 -> dram_req at c0 with addr 0x01234, bsel 11; cpu_strobe at c3; cpu_rddata=0xBEEF; cpu_latch high.
REQ-042 CPU write: cpu_wrbsel=1, wrdata=0x5A -> dram_rnw=0, bsel=10, dram_wrdata=0x5A5A; no cpu_strobe.
REQ-043 Contention: vid, cpu and dma all requesting for three slots -> owners VID,VID,VID while vid_req=1; then CPU when vid_req drops; DMA only after cpu_req drops; cpu_next=0 and dma_next=0 during video.
REQ-044 DMA address change: dma_addr changes at c1 of the granted slot -> dram_addr still shows the value captured at c3; dma_ack at c3.
REQ-045 Reset at c1 of a CPU read slot -> no cpu_strobe, all outputs at their reset values, next grant at the first c3 after release.
REQ-046 Build without ZDRAM_ARB_DMA_EN, dma_req=1 for 10 slots -> all slots idle, dma_ack never 1.
